// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: timed code stepper driving a 4-to-16 decoder select and enable.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [3:0]         first_i,
  input  logic [3:0]         last_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [3:0]         a_o,
  output logic               enable_o,
  output logic               busy_o,
  output logic               step_o,
  output logic               done_o
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic               state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         first_q, first_d, last_q, last_d, a_q, a_d, pp_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic               dir_q, dir_d, step_q, step_d, done_q, done_d;
  logic               swap;
  // In ping-pong mode first/last are stored as lo/hi; dir_q=1 means moving down.
  assign swap   = (mode_i == 2'b11) && (last_i < first_i);
  assign pp_nxt = dir_q ? a_q - 4'd1 : a_q + 4'd1;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        mode_d  = mode_i;
        first_d = swap ? last_i : first_i;
        last_d  = swap ? first_i : last_i;
        dwell_d = dwell_i;
        cnt_d   = '0;
        dir_d   = 1'b0;
        a_d     = swap ? last_i : first_i;
        step_d  = 1'b1;
      end
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (cnt_q != dwell_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        2'b00, 2'b01: begin
          if (a_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            step_d  = 1'b0;
          end else begin
            a_d = mode_q[0] ? a_q - 4'd1 : a_q + 4'd1;
          end
        end
        2'b10: a_d = (a_q == last_q) ? first_q : a_q + 4'd1;
        default: begin
          if (first_q != last_q) begin
            a_d   = pp_nxt;
            dir_d = (pp_nxt == last_q) ? 1'b1 : (pp_nxt == first_q) ? 1'b0 : dir_q;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end
  assign a_o      = a_q;
  assign enable_o = state_q;
  assign busy_o   = state_q;
  assign step_o   = step_q;
  assign done_o   = done_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed and random scans checked against a per-cycle code model.
module tb_decoder_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, stop_i = 1'b0;
  logic [1:0] mode_i = '0;
  logic [3:0] first_i = '0, last_i = '0;
  logic [7:0] dwell_i = '0;
  logic [3:0] a_o;
  logic       enable_o, busy_o, step_o, done_o;
  int passed = 0;
  int total = 0;

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .first_i(first_i), .last_i(last_i), .dwell_i(dwell_i),
    .a_o(a_o), .enable_o(enable_o), .busy_o(busy_o), .step_o(step_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int ea, input int eb, input int es, input int ed);
    chk({tag, " a"}, 32'(a_o), ea);
    chk({tag, " enable"}, 32'(enable_o), eb);
    chk({tag, " busy"}, 32'(busy_o), eb);
    chk({tag, " step"}, 32'(step_o), es);
    chk({tag, " done"}, 32'(done_o), ed);
  endtask

  // Code presented at the idx-th code slot of a scan.
  function automatic int code(input int md, input int f, input int l, input int idx);
    int n, lo, hi, sp, k;
    case (md)
      0: return (f + idx) & 15;
      1: return (f - idx) & 15;
      2: begin
        n = ((l - f) & 15) + 1;
        return (f + idx % n) & 15;
      end
      default: begin
        lo = f < l ? f : l;
        hi = f < l ? l : f;
        if (lo == hi) return lo;
        sp = hi - lo;
        k = idx % (2 * sp);
        return k <= sp ? lo + k : hi - (k - sp);
      end
    endcase
  endfunction

  function automatic int ncodes(input int md, input int f, input int l);
    return md == 1 ? ((f - l) & 15) + 1 : ((l - f) & 15) + 1;
  endfunction

  // Called before a rising edge; leaves inputs set for the edge after the last checked cycle.
  task automatic run_scan(input int md, input int f, input int l, input int d, input int ncyc,
                          input int stop_at, input bit rnd, input bit ss);
    int tt, ea, eb, es, ed;
    bit os;
    string tag;
    os = md < 2;
    tt = ncodes(md, f, l) * (d + 1);
    mode_i = 2'(md); first_i = 4'(f); last_i = 4'(l); dwell_i = 8'(d);
    start_i = 1'b1; stop_i = ss;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (stop_at >= 0 && t > stop_at) begin
        ea = code(md, f, l, stop_at / (d + 1)); eb = 0; es = 0; ed = 0;
      end else if (os && t >= tt) begin
        ea = l; eb = 0; es = 0; ed = (t == tt) ? 1 : 0;
      end else begin
        ea = code(md, f, l, t / (d + 1)); eb = 1; es = (t % (d + 1) == 0) ? 1 : 0; ed = 0;
      end
      tag = $sformatf("m%0d f%0d l%0d d%0d t%0d", md, f, l, d, t);
      chk_all(tag, ea, eb, es, ed);
      start_i = (rnd && eb == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop_i = (t == stop_at);
      if (eb == 1) begin
        mode_i = 2'($urandom); first_i = 4'($urandom); last_i = 4'($urandom); dwell_i = 8'($urandom);
      end
    end
  endtask

  initial begin
    int md, f, l, d, n;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(0, 0, 3, 0, 5, -1, 0, 0);
    run_scan(1, 1, 14, 1, 9, -1, 0, 0);
    run_scan(3, 6, 4, 0, 10, 7, 1, 0);
    run_scan(2, 14, 1, 2, 30, 27, 1, 0);
    run_scan(0, 3, 5, 1, 8, 5, 0, 0);
    run_scan(0, 5, 6, 0, 3, -1, 0, 1);
    run_scan(3, 7, 7, 1, 8, 5, 1, 0);
    run_scan(3, 2, 9, 0, 20, 18, 1, 0);
    run_scan(1, 4, 4, 2, 4, -1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      md = $urandom_range(0, 3); f = $urandom_range(0, 15); l = $urandom_range(0, 15);
      d = $urandom_range(0, 3); n = ncodes(md, f, l);
      if (md < 2) run_scan(md, f, l, d, n * (d + 1) + 1, -1, 1, 0);
      else run_scan(md, f, l, d, 40, 37, 1, 0);
    end
    run_scan(0, 2, 9, 3, 10, -1, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk_all("async reset", 0, 0, 0, 0);
    @(negedge clk);
    chk_all("held reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    run_scan(0, 2, 4, 0, 5, -1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
